fma16_seq: RTL and testbench

FMA16_SEQ -- requirements
Module: fma16_seq

---
 rtl/fma16_seq.sv | 124 ++++++++++++
 tb/tb_fma16_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma16_seq.sv
// Sequencer for a shared half-precision FMA datapath: arbitrates two requesters,
// latches operands, steps the stage enables and holds the response until accepted.
module fma16_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [15:0] req0_z,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  input  logic [15:0] req1_z,
  input  logic [4:0]  req0_ctrl,
  input  logic [4:0]  req1_ctrl,
  output logic [15:0] dp_x,
  output logic [15:0] dp_y,
  output logic [15:0] dp_z,
  output logic [4:0]  dp_ctrl,
  output logic        en_mul,
  output logic        en_align,
  output logic        en_norm,
  output logic        en_round,
  input  logic        dp_special,
  input  logic [15:0] dp_result,
  input  logic [3:0]  dp_flags,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_result,
  output logic [3:0]  resp_flags,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, MUL, ALIGN, NORM, ROUND, RESP} state_t;

  state_t      state;
  state_t      next_state;
  logic        last_grant;
  logic        grant;
  logic        grant_id;
  logic [15:0] sel_x;
  logic [15:0] sel_y;
  logic [15:0] sel_z;
  logic [4:0]  sel_ctrl;

  // Round-robin: on a tie the requester that did not win last time goes next.
  always_comb begin
    grant = (state == IDLE) && (req_valid != 2'b00) && !reset;
    if (req_valid == 2'b11) grant_id = ~last_grant;
    else                    grant_id = req_valid[1];
    sel_x    = grant_id ? req1_x    : req0_x;
    sel_y    = grant_id ? req1_y    : req0_y;
    sel_z    = grant_id ? req1_z    : req0_z;
    sel_ctrl = grant_id ? req1_ctrl : req0_ctrl;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Special results (NaN/Inf/zero/exact-z) bypass alignment and normalisation.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant) next_state = MUL;
      MUL:     next_state = dp_special ? ROUND : ALIGN;
      ALIGN:   next_state = NORM;
      NORM:    next_state = ROUND;
      ROUND:   next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 2'b00;
    en_mul     = 1'b0;
    en_align   = 1'b0;
    en_norm    = 1'b0;
    en_round   = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != IDLE);
    if (grant) req_ready[grant_id] = 1'b1;
    case (state)
      MUL:     en_mul     = 1'b1;
      ALIGN:   en_align   = 1'b1;
      NORM:    en_norm    = 1'b1;
      ROUND:   en_round   = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // A plain multiply adds zero and a plain add multiplies by one, so the
  // datapath always performs a full fused multiply-add.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_x        <= 16'h0000;
      dp_y        <= 16'h0000;
      dp_z        <= 16'h0000;
      dp_ctrl     <= 5'b00000;
      resp_id     <= 1'b0;
      last_grant  <= 1'b1;
      resp_result <= 16'h0000;
      resp_flags  <= 4'h0;
    end else begin
      if (grant) begin
        dp_x       <= sel_x;
        dp_y       <= sel_ctrl[4] ? sel_y : 16'h3C00;
        dp_z       <= sel_ctrl[3] ? sel_z : 16'h0000;
        dp_ctrl    <= sel_ctrl;
        resp_id    <= grant_id;
        last_grant <= grant_id;
      end
      if (state == ROUND) begin
        resp_result <= dp_result;
        resp_flags  <= dp_flags;
      end
    end
  end

endmodule

// File: tb/tb_fma16_seq.sv
// Scoreboard bench for fma16_seq: a stub datapath, a transaction-level model of
// arbitration and stage timing, and a monitor that checks every response.
module tb_fma16_seq;

  typedef struct packed {
    logic        id;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [4:0]  ctrl;
    logic        special;
    logic [15:0] result;
    logic [3:0]  flags;
    logic [31:0] grant_cyc;
  } op_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [15:0] req0_x = 16'h0, req0_y = 16'h0, req0_z = 16'h0;
  logic [15:0] req1_x = 16'h0, req1_y = 16'h0, req1_z = 16'h0;
  logic [4:0]  req0_ctrl = 5'h0, req1_ctrl = 5'h0;
  logic [15:0] dp_x, dp_y, dp_z;
  logic [4:0]  dp_ctrl;
  logic        en_mul, en_align, en_norm, en_round;
  logic        dp_special;
  logic [15:0] dp_result;
  logic [3:0]  dp_flags;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_id;
  logic [15:0] resp_result;
  logic [3:0]  resp_flags;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 0;
  op_t         sb_q[$];
  op_t         cur = '0;
  bit          model_busy = 1'b0;
  bit          model_last = 1'b1;
  bit          hold_valid = 1'b0;
  bit          saw_valid = 1'b0;
  bit          front_seen = 1'b0;
  int          grant_log[$];

  fma16_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z),
    .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z), .dp_ctrl(dp_ctrl),
    .en_mul(en_mul), .en_align(en_align), .en_norm(en_norm), .en_round(en_round),
    .dp_special(dp_special), .dp_result(dp_result), .dp_flags(dp_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_flags(resp_flags), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub datapath: outputs are meaningful only in their own stage and garbage otherwise.
  assign dp_special = en_mul ? dp_x[15] : ~dp_x[15];
  assign dp_result  = en_round ? (dp_x ^ {dp_y[7:0], dp_y[15:8]} ^ ~dp_z ^ {11'd0, dp_ctrl})
                               : (cyc[15:0] ^ 16'hA5A5);
  assign dp_flags   = en_round ? (dp_x[3:0] ^ dp_z[7:4] ^ dp_ctrl[3:0]) : cyc[3:0];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h cyc=%0d", name, actual, expected, cyc);
    end
  endtask

  function automatic op_t predict(input logic id, input logic [15:0] x, input logic [15:0] y,
                                  input logic [15:0] z, input logic [4:0] ctrl, input logic [31:0] gc);
    op_t o;
    o.id        = id;
    o.x         = x;
    o.y         = ctrl[4] ? y : 16'h3C00;
    o.z         = ctrl[3] ? z : 16'h0000;
    o.ctrl      = ctrl;
    o.special   = x[15];
    o.result    = o.x ^ {o.y[7:0], o.y[15:8]} ^ ~o.z ^ {11'd0, ctrl};
    o.flags     = o.x[3:0] ^ o.z[7:4] ^ ctrl[3:0];
    o.grant_cyc = gc;
    return o;
  endfunction

  task automatic applyStimulus(input int r, input logic [15:0] x, input logic [15:0] y,
                               input logic [15:0] z, input logic [4:0] c);
    if (r == 0) begin
      req0_x = x; req0_y = y; req0_z = z; req0_ctrl = c;
    end else begin
      req1_x = x; req1_y = y; req1_z = z; req1_ctrl = c;
    end
    req_valid[r] = 1'b1;
  endtask

  // One clock of the transaction model: predict grants, stage enables and held operands.
  task automatic stepCycle();
    logic [1:0] exp_ready;
    logic [3:0] exp_en;
    logic       pick;
    logic       g;
    bit         granted;
    int         k;
    @(negedge clk);
    saw_valid = resp_valid;
    granted   = 1'b0;
    g         = 1'b0;
    checkOutput("busy", {31'd0, busy}, {31'd0, model_busy});
    exp_ready = 2'b00;
    if (!model_busy && req_valid != 2'b00) begin
      if (req_valid == 2'b11) pick = (model_last == 1'b0);
      else                    pick = (req_valid == 2'b10);
      exp_ready = pick ? 2'b10 : 2'b01;
    end
    checkOutput("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
    exp_en = 4'b0000;
    if (model_busy) begin
      k = int'(cyc - cur.grant_cyc);
      if (cur.special) begin
        if (k == 0) exp_en = 4'b1000;
        else if (k == 1) exp_en = 4'b0001;
      end else if (k >= 0 && k < 4) begin
        exp_en = 4'b1000 >> k;
      end
    end
    checkOutput("enables", {28'd0, en_mul, en_align, en_norm, en_round}, {28'd0, exp_en});
    checkOutput("dp_x", {16'd0, dp_x}, {16'd0, cur.x});
    checkOutput("dp_y", {16'd0, dp_y}, {16'd0, cur.y});
    checkOutput("dp_z", {16'd0, dp_z}, {16'd0, cur.z});
    checkOutput("dp_ctrl", {27'd0, dp_ctrl}, {27'd0, cur.ctrl});
    if (req_ready == 2'b01 || req_ready == 2'b10) begin
      g = req_ready[1];
      granted = 1'b1;
      cur = g ? predict(1'b1, req1_x, req1_y, req1_z, req1_ctrl, cyc + 1)
              : predict(1'b0, req0_x, req0_y, req0_z, req0_ctrl, cyc + 1);
      sb_q.push_back(cur);
      model_busy = 1'b1;
      model_last = g;
      grant_log.push_back(int'(g));
    end else if (resp_valid && resp_ready) begin
      model_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    if (granted && !hold_valid) req_valid[g] = 1'b0;
  endtask

  task automatic waitGrant(input string name);
    int n = 0;
    while (!model_busy && n < 20) begin stepCycle(); n++; end
    checkOutput({name, "_granted"}, {31'd0, model_busy}, 32'd1);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (model_busy && n < 40) begin stepCycle(); n++; end
    checkOutput({name, "_done"}, {31'd0, model_busy}, 32'd0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((req_valid != 2'b00 || model_busy) && n < 100) begin stepCycle(); n++; end
    checkOutput({name, "_drained"}, {30'd0, req_valid, 1'b0, model_busy}, 32'd0);
  endtask

  // Monitor: each presented response is compared against the oldest outstanding op.
  always @(negedge clk) begin
    op_t exp_op;
    if (reset) begin
      front_seen = 1'b0;
    end else if (resp_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_resp actual=valid expected=no_response cyc=%0d", cyc);
      end else begin
        exp_op = sb_q[0];
        if (!front_seen) begin
          checkOutput("latency", cyc - exp_op.grant_cyc, exp_op.special ? 32'd2 : 32'd4);
          front_seen = 1'b1;
        end
        checkOutput("resp_id", {31'd0, resp_id}, {31'd0, exp_op.id});
        checkOutput("resp_result", {16'd0, resp_result}, {16'd0, exp_op.result});
        checkOutput("resp_flags", {28'd0, resp_flags}, {28'd0, exp_op.flags});
        if (resp_ready) begin
          void'(sb_q.pop_front());
          front_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    // Reset state, with both requesters already asking.
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(0, 16'h1111, 16'h2222, 16'h3333, 5'b11000);
    applyStimulus(1, 16'h4444, 16'h5555, 16'h6666, 5'b11000);
    @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("rst_enables", {28'd0, en_mul, en_align, en_norm, en_round}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_dp_x", {16'd0, dp_x}, 32'd0);
    checkOutput("rst_dp_y", {16'd0, dp_y}, 32'd0);
    checkOutput("rst_dp_z", {16'd0, dp_z}, 32'd0);
    checkOutput("rst_dp_ctrl", {27'd0, dp_ctrl}, 32'd0);
    checkOutput("rst_resp_result", {16'd0, resp_result}, 32'd0);
    checkOutput("rst_resp_flags", {28'd0, resp_flags}, 32'd0);
    checkOutput("rst_resp_id", {31'd0, resp_id}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Tie fairness: both held valid, four operations must alternate from requester 0.
    hold_valid = 1'b1;
    resp_ready = 1'b1;
    grant_log.delete();
    for (int n = 0; n < 60 && grant_log.size() < 4; n++) stepCycle();
    req_valid  = 2'b00;
    hold_valid = 1'b0;
    waitDone("tie");
    checkOutput("tie_count", grant_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      checkOutput("tie_order", grant_log[i], i % 2);

    // Single normal-path request.
    applyStimulus(0, 16'h3C00, 16'h4000, 16'h0000, 5'b11000);
    waitGrant("single");
    waitDone("single");

    // Special path skips ALIGN and NORM.
    applyStimulus(1, 16'hC000, 16'h4000, 16'h3C00, 5'b11000);
    waitGrant("special");
    waitDone("special");

    // Backpressure with new requests pending behind the held response.
    resp_ready = 1'b0;
    applyStimulus(0, 16'h0ABC, 16'h1357, 16'h2468, 5'b11010);
    waitGrant("bp");
    for (int n = 0; n < 20 && !saw_valid; n++) stepCycle();
    checkOutput("bp_reached_resp", {31'd0, saw_valid}, 32'd1);
    applyStimulus(0, 16'h0101, 16'h0202, 16'h0303, 5'b11001);
    applyStimulus(1, 16'h0404, 16'h0505, 16'h0606, 5'b11100);
    repeat (5) begin
      stepCycle();
      checkOutput("bp_valid_held", {31'd0, saw_valid}, 32'd1);
    end
    resp_ready = 1'b1;
    drain("bp");

    // Reset asserted while the operation is in NORM.
    hold_valid = 1'b1;
    applyStimulus(0, 16'h1357, 16'h2222, 16'h0F0F, 5'b11000);
    waitGrant("rstnorm");
    stepCycle();
    stepCycle();
    checkOutput("pre_reset_norm", {31'd0, en_norm}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_enables", {28'd0, en_mul, en_align, en_norm, en_round}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    sb_q.delete();
    cur        = '0;
    model_busy = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_req_ready", {30'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    hold_valid = 1'b0;
    waitGrant("regrant");
    waitDone("regrant");

    // Operand substitution for multiply-only and add-only requests.
    applyStimulus(0, 16'h2468, 16'h1234, 16'h7777, 5'b01000);
    waitGrant("sub_add");
    checkOutput("sub_dp_y_one", {16'd0, dp_y}, 32'h3C00);
    checkOutput("sub_dp_z_kept", {16'd0, dp_z}, 32'h7777);
    waitDone("sub_add");
    applyStimulus(1, 16'h1111, 16'h4200, 16'h5555, 5'b10000);
    waitGrant("sub_mul");
    checkOutput("sub_dp_z_zero", {16'd0, dp_z}, 32'h0000);
    checkOutput("sub_dp_y_kept", {16'd0, dp_y}, 32'h4200);
    waitDone("sub_mul");

    // Randomised traffic: arrivals, withdrawals, operand churn and backpressure.
    for (int n = 0; n < 1500; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req_valid[r]) begin
          if ($urandom_range(0, 2) == 0)
            applyStimulus(r, 16'($urandom), 16'($urandom), 16'($urandom), 5'($urandom));
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[r] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          applyStimulus(r, 16'($urandom), 16'($urandom), 16'($urandom), 5'($urandom));
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      stepCycle();
    end
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    drain("final");
    checkOutput("scoreboard_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
